// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin message-granular arbiter sharing one UART transmit write port
module uart_tx_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       write_tx_data,
  input  logic       tx_buffer_full,
  output logic [1:0] grant,
  output logic       busy
);

  // Counter only needs to reach LOCK_TIMEOUT; keep at least one bit when disabled.
  localparam int unsigned CW      = (LOCK_TIMEOUT == 0) ? 1 : $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned TO_LAST = (LOCK_TIMEOUT == 0) ? 0 : LOCK_TIMEOUT - 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TO_LAST);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LOCK_TIMEOUT);
  localparam bit TIMEOUT_ON = (LOCK_TIMEOUT != 0);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t        state;
  logic          ptr;
  logic [CW-1:0] cnt;

  logic       owner;
  logic       o_valid;
  logic       o_last;
  logic [7:0] o_data;
  logic       can_send;
  logic       xfer;

  // Mux the current owner's stream; grant[1] selects requester 1.
  assign owner   = grant[1];
  assign o_valid = owner ? req1_valid : req0_valid;
  assign o_last  = owner ? req1_last  : req0_last;
  assign o_data  = owner ? req1_data  : req0_data;

  // Blocking the cycle right after a strobe covers the UART's late full flag.
  assign can_send   = (state == LOCK) & ~tx_buffer_full & ~write_tx_data;
  assign req0_ready = can_send & grant[0];
  assign req1_ready = can_send & grant[1];
  assign xfer       = can_send & o_valid;

  // Arbitration FSM: IDLE picks a winner, LOCK streams its bytes until last or idle timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= 2'b00;
      busy          <= 1'b0;
      write_tx_data <= 1'b0;
      tx_data       <= 8'h00;
      cnt           <= '0;
      ptr           <= 1'b0;
    end else begin
      write_tx_data <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (req0_valid | req1_valid) begin
            state <= LOCK;
            busy  <= 1'b1;
            if (req0_valid & (~req1_valid | ~ptr)) begin
              grant <= 2'b01;
            end else begin
              grant <= 2'b10;
            end
          end
        end
        LOCK: begin
          if (xfer) begin
            write_tx_data <= 1'b1;
            tx_data       <= o_data;
            cnt           <= '0;
            if (o_last) begin
              state <= IDLE;
              grant <= 2'b00;
              busy  <= 1'b0;
              ptr   <= ~owner;
            end
          end else if (TIMEOUT_ON && !o_valid) begin
            // Only genuine owner silence counts; a stalled but valid owner holds the count.
            if (cnt == CNT_LAST) begin
              state <= IDLE;
              grant <= 2'b00;
              busy  <= 1'b0;
              ptr   <= ~owner;
              cnt   <= '0;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req1_valid, req0_last, req1_last;
  logic       req0_ready, req1_ready;
  logic [7:0] tx_data;
  logic       write_tx_data;
  logic       tx_buffer_full;
  logic [1:0] grant;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] seen[$];
  int         seen_cyc[$];
  logic [1:0] gh[$];

  always #5 clk = ~clk;

  uart_tx_arbiter #(.LOCK_TIMEOUT(10)) dut (
    .clk(clk), .reset(reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data(tx_data), .write_tx_data(write_tx_data), .tx_buffer_full(tx_buffer_full),
    .grant(grant), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h00; req0_last = 1'b0;
    req1_valid = 1'b0; req1_data = 8'h00; req1_last = 1'b0;
    tx_buffer_full = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drive_heads();
    req0_valid = (q0.size() > 0);
    req1_valid = (q1.size() > 0);
    req0_data = 8'h00; req0_last = 1'b0;
    req1_data = 8'h00; req1_last = 1'b0;
    if (q0.size() > 0) begin
      req0_data = q0[0][7:0];
      req0_last = q0[0][8];
    end
    if (q1.size() > 0) begin
      req1_data = q1[0][7:0];
      req1_last = q1[0][8];
    end
  endtask

  // Requester models pop a byte on each valid&ready edge; a monitor logs strobes and grant changes.
  task automatic run_queues(input int max_cycles);
    int cyc;
    bit acc0, acc1;
    cyc = 0;
    seen.delete();
    seen_cyc.delete();
    gh.delete();
    gh.push_back(grant);
    drive_heads();
    while ((q0.size() > 0 || q1.size() > 0) && cyc < max_cycles) begin
      #1;
      acc0 = req0_valid && req0_ready;
      acc1 = req1_valid && req1_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc0) void'(q0.pop_front());
      if (acc1) void'(q1.pop_front());
      if (write_tx_data) begin
        seen.push_back(tx_data);
        seen_cyc.push_back(cyc);
      end
      if (gh[gh.size()-1] != grant) gh.push_back(grant);
      drive_heads();
    end
    chk("drain_left", 32'(q0.size() + q1.size()), 32'd0);
  endtask

  function automatic logic [7:0] seen_at(input int i);
    return (i < seen.size()) ? seen[i] : 8'hEE;
  endfunction

  function automatic logic [1:0] gh_at(input int i);
    return (i < gh.size()) ? gh[i] : 2'b11;
  endfunction

  initial begin
    logic [7:0] exp3[12];
    logic [1:0] prev;
    int nz;
    int wr_cnt;
    int rel_cnt;

    // Reset state
    do_reset();
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_write", 32'(write_tx_data), 32'd0);
    chk("rst_txdata", 32'(tx_data), 32'h00);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);

    // 1. Single requester 0x41,0x42,0x43
    req0_valid = 1'b1; req0_data = 8'h41; req0_last = 1'b0;   // cycle t
    tick();                                                     // t+1
    chk("t1_grant_t1", 32'(grant), 32'd1);
    chk("t1_busy_t1", 32'(busy), 32'd1);
    chk("t1_ready_t1", 32'(req0_ready), 32'd1);
    chk("t1_write_t1", 32'(write_tx_data), 32'd0);
    tick();                                                     // t+2
    chk("t1_write_t2", 32'(write_tx_data), 32'd1);
    chk("t1_data_t2", 32'(tx_data), 32'h41);
    chk("t1_ready_t2", 32'(req0_ready), 32'd0);
    req0_data = 8'h42;
    tick();                                                     // t+3
    chk("t1_write_t3", 32'(write_tx_data), 32'd0);
    chk("t1_data_hold_t3", 32'(tx_data), 32'h41);
    tick();                                                     // t+4
    chk("t1_write_t4", 32'(write_tx_data), 32'd1);
    chk("t1_data_t4", 32'(tx_data), 32'h42);
    chk("t1_grant_t4", 32'(grant), 32'd1);
    req0_data = 8'h43; req0_last = 1'b1;
    tick();                                                     // t+5
    chk("t1_grant_t5", 32'(grant), 32'd1);
    tick();                                                     // t+6
    chk("t1_write_t6", 32'(write_tx_data), 32'd1);
    chk("t1_data_t6", 32'(tx_data), 32'h43);
    chk("t1_grant_t6", 32'(grant), 32'd0);
    chk("t1_busy_t6", 32'(busy), 32'd0);
    req0_valid = 1'b0; req0_last = 1'b0;
    tick();                                                     // t+7
    chk("t1_write_t7", 32'(write_tx_data), 32'd0);
    chk("t1_grant_t7", 32'(grant), 32'd0);

    // 2. Simultaneous first request, 2-byte messages
    do_reset();
    q0 = '{9'h0A0, 9'h1A1};
    q1 = '{9'h0B0, 9'h1B1};
    run_queues(100);
    chk("t2_count", 32'(seen.size()), 32'd4);
    chk("t2_b0", 32'(seen_at(0)), 32'hA0);
    chk("t2_b1", 32'(seen_at(1)), 32'hA1);
    chk("t2_b2", 32'(seen_at(2)), 32'hB0);
    chk("t2_b3", 32'(seen_at(3)), 32'hB1);
    chk("t2_first_cyc", 32'((seen_cyc.size() > 0) ? seen_cyc[0] : -1), 32'd2);
    chk("t2_b2_cyc", 32'((seen_cyc.size() > 2) ? seen_cyc[2] : -1), 32'd6);
    chk("t2_gh1", 32'(gh_at(1)), 32'd1);
    chk("t2_gh2", 32'(gh_at(2)), 32'd0);
    chk("t2_gh3", 32'(gh_at(3)), 32'd2);

    // 3. Fairness: continuous 2-byte messages from both
    do_reset();
    q0 = '{9'h0A0, 9'h1A1, 9'h0A2, 9'h1A3, 9'h0A4, 9'h1A5};
    q1 = '{9'h0B0, 9'h1B1, 9'h0B2, 9'h1B3, 9'h0B4, 9'h1B5};
    exp3 = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hA2, 8'hA3, 8'hB2, 8'hB3, 8'hA4, 8'hA5, 8'hB4, 8'hB5};
    run_queues(300);
    chk("t3_count", 32'(seen.size()), 32'd12);
    for (int i = 0; i < 12; i++) chk($sformatf("t3_byte%0d", i), 32'(seen_at(i)), 32'(exp3[i]));
    prev = 2'b00;
    nz = 0;
    for (int i = 0; i < gh.size(); i++) begin
      if (gh[i] != 2'b00) begin
        if (nz > 0) chk($sformatf("t3_alt%0d", nz), 32'(gh[i] != prev), 32'd1);
        prev = gh[i];
        nz++;
      end
    end
    chk("t3_grants", 32'(nz), 32'd6);

    // 4. Backpressure: full for 50 cycles mid-message
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h51; req0_last = 1'b0;   // t
    tick();                                                     // t+1
    tick();                                                     // t+2
    chk("t4_write_t2", 32'(write_tx_data), 32'd1);
    chk("t4_data_t2", 32'(tx_data), 32'h51);
    req0_data = 8'h52; req0_last = 1'b1;
    tx_buffer_full = 1'b1;
    wr_cnt = 0;
    rel_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (write_tx_data) wr_cnt++;
      if (grant != 2'b01) rel_cnt++;
    end
    chk("t4_no_writes", 32'(wr_cnt), 32'd0);
    chk("t4_no_release", 32'(rel_cnt), 32'd0);
    tx_buffer_full = 1'b0;
    #1;
    chk("t4_ready_resume", 32'(req0_ready), 32'd1);
    tick();
    chk("t4_write_resume", 32'(write_tx_data), 32'd1);
    chk("t4_data_resume", 32'(tx_data), 32'h52);
    chk("t4_grant_end", 32'(grant), 32'd0);
    req0_valid = 1'b0; req0_last = 1'b0;

    // 5. Timeout with LOCK_TIMEOUT = 10
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h61; req0_last = 1'b0;   // t
    req1_valid = 1'b1; req1_data = 8'h71; req1_last = 1'b1;
    tick();                                                     // t+1
    chk("t5_grant_t1", 32'(grant), 32'd1);
    chk("t5_nonowner_ready", 32'(req1_ready), 32'd0);
    tick();                                                     // t+2
    chk("t5_data_t2", 32'(tx_data), 32'h61);
    req0_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();                         // t+11
    chk("t5_grant_t11", 32'(grant), 32'd1);
    tick();                                                     // t+12
    chk("t5_grant_t12", 32'(grant), 32'd0);
    tick();                                                     // t+13
    chk("t5_grant_t13", 32'(grant), 32'd2);
    tick();                                                     // t+14
    chk("t5_write_t14", 32'(write_tx_data), 32'd1);
    chk("t5_data_t14", 32'(tx_data), 32'h71);
    req1_valid = 1'b0; req1_last = 1'b0;

    // 6. Reset mid-transfer; pointer left at 1 beforehand
    do_reset();
    req0_valid = 1'b1; req0_data = 8'h80; req0_last = 1'b1;
    tick(); tick();
    chk("t6_pre_write", 32'(write_tx_data), 32'd1);
    req0_data = 8'h81; req0_last = 1'b0;                       // t (IDLE, ptr=1)
    tick();                                                     // t+1
    chk("t6_grant_t1", 32'(grant), 32'd1);
    chk("t6_xfer_ready", 32'(req0_ready), 32'd1);
    reset = 1'b1;
    tick();                                                     // t+2
    chk("t6_write_after_rst", 32'(write_tx_data), 32'd0);
    chk("t6_grant_after_rst", 32'(grant), 32'd0);
    chk("t6_busy_after_rst", 32'(busy), 32'd0);
    reset = 1'b0;
    req0_valid = 1'b1; req0_data = 8'h91; req0_last = 1'b1;
    req1_valid = 1'b1; req1_data = 8'h92; req1_last = 1'b1;
    tick();                                                     // t+3
    chk("t6_tie_winner", 32'(grant), 32'd1);
    tick();
    tick();
    chk("t6_tie_data", 32'(tx_data), 32'h91);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
